// File: rtl/dac_spi_channel.sv
// Single-channel SPI master (mode 1) for one DAC port group.
// Shifts a latched frame out MSB-first, captures Miso and pulses Done at the end.
module dac_spi_channel #(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = 24,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_IDLE   = 2
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 Start,
    input  logic [1:0]           CsSel,
    input  logic [WORD_BITS-1:0] TxData,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Done,
    output logic [WORD_BITS-1:0] RxData,
    output logic                 Mosi,
    output logic                 Sck,
    output logic [3:0]           nCs,
    input  logic                 Miso
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(WORD_BITS + 1);
    localparam int PH_MAX = (CS_SETUP > CS_HOLD)
                          ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                          : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(WORD_BITS);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(CS_IDLE);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } stateT;

    stateT                state, stateNext;
    logic [DIV_W-1:0]     divCnt, divCntNext;
    logic [BIT_W-1:0]     bitCnt, bitCntNext;
    logic [PH_W-1:0]      phaseCnt, phaseCntNext;
    logic [WORD_BITS-1:0] txShift, txShiftNext;
    logic [WORD_BITS-1:0] rxShift, rxShiftNext;
    logic [WORD_BITS-1:0] rxDataNext;
    logic                 mosiNext, sckNext, doneNext;
    logic [3:0]           nCsNext;

    assign Ready = (state == IDLE);
    assign Busy  = ~Ready;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= IDLE;
            divCnt   <= '0;
            bitCnt   <= '0;
            phaseCnt <= '0;
            txShift  <= '0;
            rxShift  <= '0;
            RxData   <= '0;
            Mosi     <= 1'b0;
            Sck      <= 1'b0;
            nCs      <= 4'hF;
            Done     <= 1'b0;
        end else begin
            state    <= stateNext;
            divCnt   <= divCntNext;
            bitCnt   <= bitCntNext;
            phaseCnt <= phaseCntNext;
            txShift  <= txShiftNext;
            rxShift  <= rxShiftNext;
            RxData   <= rxDataNext;
            Mosi     <= mosiNext;
            Sck      <= sckNext;
            nCs      <= nCsNext;
            Done     <= doneNext;
        end
    end

    // GAP runs one cycle past CS_IDLE so Done lands on the documented latency
    // and a Start taken in the Done cycle still sees the full idle gap.
    always_comb begin
        stateNext    = state;
        divCntNext   = divCnt;
        bitCntNext   = bitCnt;
        phaseCntNext = phaseCnt;
        txShiftNext  = txShift;
        rxShiftNext  = rxShift;
        rxDataNext   = RxData;
        mosiNext     = Mosi;
        sckNext      = Sck;
        nCsNext      = nCs;
        doneNext     = 1'b0;

        unique case (state)
            IDLE: begin
                mosiNext = 1'b0;
                sckNext  = 1'b0;
                if (Start) begin
                    txShiftNext  = TxData;
                    rxShiftNext  = '0;
                    nCsNext      = ~(4'b0001 << CsSel);
                    phaseCntNext = '0;
                    stateNext    = SETUP;
                end
            end

            SETUP: begin
                if (phaseCnt == SETUP_LAST) begin
                    sckNext     = 1'b1;
                    mosiNext    = txShift[WORD_BITS-1];
                    txShiftNext = {txShift[WORD_BITS-2:0], 1'b0};
                    divCntNext  = '0;
                    bitCntNext  = '0;
                    stateNext   = SHIFT;
                end else begin
                    phaseCntNext = phaseCnt + 1'b1;
                end
            end

            SHIFT: begin
                if (divCnt == DIV_LAST) begin
                    divCntNext = '0;
                    if (Sck) begin
                        sckNext     = 1'b0;
                        rxShiftNext = {rxShift[WORD_BITS-2:0], Miso};
                        bitCntNext  = bitCnt + 1'b1;
                    end else if (bitCnt == BITS_ALL) begin
                        mosiNext     = 1'b0;
                        phaseCntNext = '0;
                        stateNext    = HOLD;
                    end else begin
                        sckNext     = 1'b1;
                        mosiNext    = txShift[WORD_BITS-1];
                        txShiftNext = {txShift[WORD_BITS-2:0], 1'b0};
                    end
                end else begin
                    divCntNext = divCnt + 1'b1;
                end
            end

            HOLD: begin
                if (phaseCnt == HOLD_LAST) begin
                    nCsNext      = 4'hF;
                    phaseCntNext = '0;
                    stateNext    = GAP;
                end else begin
                    phaseCntNext = phaseCnt + 1'b1;
                end
            end

            GAP: begin
                if (phaseCnt == GAP_LAST) begin
                    doneNext     = 1'b1;
                    rxDataNext   = rxShift;
                    phaseCntNext = '0;
                    stateNext    = IDLE;
                end else begin
                    phaseCntNext = phaseCnt + 1'b1;
                end
            end

            default: begin
                nCsNext   = 4'hF;
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_spi_channel.sv
// Self-checking bench for dac_spi_channel: default instance plus a small-parameter instance,
// checked against frame-level expectations (latency formula, bit order, Miso readback).
module tb_dac_spi_channel;

    localparam int DIV = 4, WB = 24, SU = 2, HO = 2, ID = 2;
    localparam int N_DEF = SU + 2 * WB * DIV + HO + ID + 1;
    localparam int DIV2 = 2, WB2 = 16;
    localparam int N_OVR = 1 + 2 * WB2 * DIV2 + 1 + 1 + 1;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  CsSel = 2'd0;
    logic [23:0] TxData = '0;
    logic        Ready, Busy, Done, Mosi, Sck, Miso;
    logic [23:0] RxData;
    logic [3:0]  nCs;
    logic [1:0]  misoMode = 2'd0;

    logic        start2 = 1'b0;
    logic [15:0] txData2 = '0;
    logic        ready2, busy2, done2, mosi2, sck2;
    logic [15:0] rxData2;
    logic [3:0]  nCs2;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    assign Miso = (misoMode == 2'd0) ? Mosi :
                  (misoMode == 2'd1) ? ~Mosi :
                  (misoMode == 2'd2) ? 1'b1 : 1'b0;

    dac_spi_channel dut (
        .clk(clk), .nRst(nRst), .Start(Start), .CsSel(CsSel), .TxData(TxData),
        .Ready(Ready), .Busy(Busy), .Done(Done), .RxData(RxData),
        .Mosi(Mosi), .Sck(Sck), .nCs(nCs), .Miso(Miso)
    );

    dac_spi_channel #(.CLK_DIV(2), .WORD_BITS(16), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut2 (
        .clk(clk), .nRst(nRst), .Start(start2), .CsSel(2'd1), .TxData(txData2),
        .Ready(ready2), .Busy(busy2), .Done(done2), .RxData(rxData2),
        .Mosi(mosi2), .Sck(sck2), .nCs(nCs2), .Miso(mosi2)
    );

    int          cycleCnt = 0;
    int          riseCnt = 0, lastRise = 0, spacingBad = 0, nCsBad = 0, doneCnt = 0, csShapeBad = 0;
    logic        prevSck = 1'b0;
    logic [23:0] mosiWord = '0;
    logic [3:0]  expNcs = 4'hF;
    int          riseCnt2 = 0, lastRise2 = 0, spacingBad2 = 0;
    logic        prevSck2 = 1'b0;

    always @(posedge clk) cycleCnt++;

    // Frame observers: Sck rise spacing, Mosi bit stream, nCs seen at each rise.
    always @(negedge clk) begin
        if (Sck && !prevSck) begin
            if (riseCnt > 0 && (cycleCnt - lastRise) != 2 * DIV) spacingBad++;
            lastRise = cycleCnt;
            riseCnt++;
            mosiWord = {mosiWord[22:0], Mosi};
            if (nCs !== expNcs) nCsBad++;
        end
        prevSck = Sck;
        if (Done) doneCnt++;
        if (!(nCs == 4'hF || nCs == 4'b1110 || nCs == 4'b1101 || nCs == 4'b1011 || nCs == 4'b0111))
            csShapeBad++;
        if (sck2 && !prevSck2) begin
            if (riseCnt2 > 0 && (cycleCnt - lastRise2) != 2 * DIV2) spacingBad2++;
            lastRise2 = cycleCnt;
            riseCnt2++;
        end
        prevSck2 = sck2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] expectedRx(input logic [23:0] tx, input logic [1:0] mode);
        case (mode)
            2'd0:    return tx;
            2'd1:    return ~tx;
            2'd2:    return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!Ready && n < 500) begin @(negedge clk); n++; end
        checkOutput("readyBeforeStart", Ready, 1);
    endtask

    task automatic applyStimulus(input logic [23:0] tx, input logic [1:0] sel, input logic [1:0] mode);
        int startEdge, n;
        waitReady();
        misoMode = mode;
        expNcs = 4'hF & ~(4'b0001 << sel);
        riseCnt = 0; spacingBad = 0; nCsBad = 0; mosiWord = '0;
        Start = 1'b1; TxData = tx; CsSel = sel;
        startEdge = cycleCnt + 1;
        @(negedge clk);
        Start = 1'b0; TxData = 24'($urandom); CsSel = 2'($urandom);
        checkOutput("nCsAfterStart", nCs, expNcs);
        checkOutput("busyAfterStart", Busy, 1);
        n = 0;
        while (!Done && n < 400) begin @(negedge clk); n++; end
        checkOutput("doneSeen", Done, 1);
        checkOutput("latency", cycleCnt - startEdge, N_DEF);
        checkOutput("rxData", RxData, expectedRx(tx, mode));
        checkOutput("sckRises", riseCnt, WB);
        checkOutput("sckSpacing", spacingBad, 0);
        checkOutput("mosiBits", mosiWord, tx);
        checkOutput("nCsDuringFrame", nCsBad, 0);
        @(negedge clk);
        checkOutput("donePulseWidth", Done, 0);
        checkOutput("readyAfterDone", Ready, 1);
    endtask

    initial begin
        int e0, n, snap;
        logic [23:0] tx1, tx2, held;

        // Reset and idle
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("resetNcs", nCs, 4'hF);
        checkOutput("resetSck", Sck, 0);
        checkOutput("resetMosi", Mosi, 0);
        checkOutput("resetReady", Ready, 1);
        checkOutput("resetBusy", Busy, 0);
        checkOutput("resetDone", Done, 0);
        checkOutput("resetRxData", RxData, 0);

        // Directed frames: loopback pattern and Miso tied high with zero data
        applyStimulus(24'hA5C3F0, 2'd2, 2'd0);
        applyStimulus(24'h000000, 2'd0, 2'd2);

        // RxData holds through an idle stretch
        held = RxData;
        repeat (20) @(negedge clk);
        checkOutput("rxHoldIdle", RxData, held);

        // Randomized frames with assorted Miso behaviour
        for (int i = 0; i < 4; i++)
            applyStimulus(24'($urandom), 2'($urandom), 2'($urandom));

        // Start held through a frame, then a new request in the Done cycle
        waitReady();
        tx1 = 24'($urandom); tx2 = 24'($urandom);
        misoMode = 2'd0; expNcs = 4'b1110;
        riseCnt = 0; mosiWord = '0;
        snap = doneCnt;
        Start = 1'b1; TxData = tx1; CsSel = 2'd0;
        e0 = cycleCnt + 1;
        @(negedge clk);
        TxData = 24'($urandom); CsSel = 2'd2;
        n = 0;
        while (!Done && n < 400) begin @(negedge clk); n++; end
        checkOutput("b2bFirstLatency", cycleCnt - e0, N_DEF);
        checkOutput("b2bFirstRx", RxData, tx1);
        checkOutput("b2bFirstBits", mosiWord, tx1);
        TxData = tx2; CsSel = 2'd3; expNcs = 4'b0111;
        riseCnt = 0; mosiWord = '0;
        @(negedge clk);
        Start = 1'b0;
        checkOutput("b2bNcsNext", nCs, 4'b0111);
        n = 0;
        while (!Done && n < 400) begin @(negedge clk); n++; end
        checkOutput("b2bSecondLatency", cycleCnt - e0, 2 * N_DEF + 1);
        checkOutput("b2bSecondRx", RxData, tx2);
        while (cycleCnt < e0 + 400) @(negedge clk);
        checkOutput("b2bDoneCount", doneCnt - snap, 2);

        // Reset pulse mid-frame after the 10th Sck rise
        waitReady();
        riseCnt = 0; expNcs = 4'b1101;
        Start = 1'b1; TxData = 24'($urandom); CsSel = 2'd1;
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (riseCnt < 10 && n < 200) begin @(negedge clk); n++; end
        checkOutput("tenthRise", riseCnt, 10);
        nRst = 1'b0;
        snap = doneCnt;
        @(negedge clk);
        nRst = 1'b1;
        checkOutput("midResetNcs", nCs, 4'hF);
        checkOutput("midResetSck", Sck, 0);
        checkOutput("midResetReady", Ready, 1);
        checkOutput("midResetRx", RxData, 0);
        repeat (250) @(negedge clk);
        checkOutput("midResetNoDone", doneCnt - snap, 0);
        applyStimulus(24'($urandom), 2'd1, 2'd1);

        // Small-parameter instance
        riseCnt2 = 0; spacingBad2 = 0;
        txData2 = 16'($urandom);
        start2 = 1'b1;
        e0 = cycleCnt + 1;
        @(negedge clk);
        start2 = 1'b0;
        tx1 = {8'h00, txData2};
        txData2 = 16'($urandom);
        n = 0;
        while (!done2 && n < 200) begin @(negedge clk); n++; end
        checkOutput("ovrLatency", cycleCnt - e0, N_OVR);
        checkOutput("ovrRises", riseCnt2, WB2);
        checkOutput("ovrSpacing", spacingBad2, 0);
        checkOutput("ovrRx", {8'h00, rxData2}, tx1);

        checkOutput("nCsOneHotLow", csShapeBad, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
